mult_div_unit: RTL and testbench

//   Multi-cycle multiply/divide unit with HI/LO registers; sits in the E stage beside the ALU.

---
 rtl/mult_div_unit.sv | 148 ++++++++++++++
 tb/tb_mult_div_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, placed in the E stage.
// A start pulse in idle latches the operands and op, then busy stays high for a fixed
// number of cycles before hi/lo take the result. MTHI/MTLO writes land only while idle.
// Optional feature macro: MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops
// (ops 4-7); without it those ops are ignored and no 64-bit accumulator adder exists.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        mt_we_i,
  input  logic        mt_hi_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic        op_ok;
  logic        is_div;
  logic        div_signed;
  logic [63:0] prod_s, prod_u;
  logic [31:0] dvd, dvs, dvs_safe, uq, ur, quo, rem;
  logic [63:0] result;

  // Ops the build can execute; accumulate ops are rejected when the feature is compiled out.
  always_comb begin
`ifdef MDU_MADD_EN
    op_ok = 1'b1;
`else
    op_ok = ~op_i[2];
`endif
    is_div = (op_i == 3'd2) || (op_i == 3'd3);
  end

  // Arithmetic on latched operands; divide works on magnitudes to avoid INT_MIN/-1 overflow.
  always_comb begin
    prod_s     = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u     = {32'd0, a_q} * {32'd0, b_q};
    div_signed = (op_q == 3'd2);
    dvd        = (div_signed && a_q[31]) ? -a_q : a_q;
    dvs        = (div_signed && b_q[31]) ? -b_q : b_q;
    dvs_safe   = (dvs == 32'd0) ? 32'd1 : dvs;
    uq         = dvd / dvs_safe;
    ur         = dvd % dvs_safe;
    quo        = (div_signed && (a_q[31] ^ b_q[31])) ? -uq : uq;
    rem        = (div_signed && a_q[31]) ? -ur : ur;
    result     = {hi_q, lo_q};
    case (op_q)
      3'd0: result = prod_s;
      3'd1: result = prod_u;
      3'd2,
      3'd3: result = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem, quo};
`ifdef MDU_MADD_EN
      3'd4: result = {hi_q, lo_q} + prod_s;
      3'd5: result = {hi_q, lo_q} + prod_u;
      3'd6: result = {hi_q, lo_q} - prod_s;
      3'd7: result = {hi_q, lo_q} - prod_u;
`endif
      default: result = {hi_q, lo_q};
    endcase
  end

  // Next-state: launch from idle, count down in run, write hi/lo on the final edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          // start always takes priority over a same-cycle MTHI/MTLO
          if (op_ok) begin
            op_d    = op_i;
            a_d     = a_i;
            b_d     = b_i;
            cnt_d   = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            state_d = StRun;
          end
        end else if (mt_we_i) begin
          if (mt_hi_i) hi_d = b_i;
          else         lo_d = b_i;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          hi_d    = result[63:32];
          lo_d    = result[31:0];
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

`ifndef SYNTHESIS
  // The stall logic must never issue a new op while one is in flight.
  start_while_busy: assert property (@(posedge clk_i) disable iff (reset_i)
                                     !(start_i && busy_o))
    else $error("mult_div_unit: start asserted while busy");
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected hi/lo are queued at launch and checked
// when busy falls; also covers MTHI/MTLO, reset abort and the accumulate build option.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        mt_we, mt_hi;
  logic        busy;
  logic [31:0] hi, lo;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned n;
  } exp_t;

  exp_t sb[$];

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .mt_we_i (mt_we),
    .mt_hi_i (mt_hi),
    .busy_o  (busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one op, push its expectation, then pop and compare when busy drops.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                        input int unsigned n, input bit same_mt, input bit mid_mt);
    exp_t        e;
    int unsigned cyc;
    logic [31:0] pre_hi, pre_lo;
    bit          held;
    e.tag = tag; e.hi = ehi; e.lo = elo; e.n = n;
    sb.push_back(e);
    @(negedge clk);
    pre_hi = hi; pre_lo = lo;
    start = 1'b1; op = o; a = va; b = vb; mt_we = same_mt; mt_hi = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mt_we = 1'b0;
    cyc  = 0;
    held = 1'b1;
    @(negedge clk);
    while (busy && cyc < 200) begin
      cyc++;
      if (hi !== pre_hi || lo !== pre_lo) held = 1'b0;
      if (mid_mt && cyc == 2) begin
        mt_we = 1'b1; mt_hi = 1'b1; b = 32'hDEAD_BEEF;
      end else begin
        mt_we = 1'b0;
      end
      @(negedge clk);
    end
    mt_we = 1'b0;
    e = sb.pop_front();
    check({e.tag, "/busy_cycles"}, 32'(cyc), 32'(e.n));
    check({e.tag, "/hold"}, 32'(held), 32'd1);
    check({e.tag, "/hi"}, hi, e.hi);
    check({e.tag, "/lo"}, lo, e.lo);
  endtask

  task automatic mt_write(input bit to_hi, input logic [31:0] v);
    @(negedge clk);
    mt_we = 1'b1; mt_hi = to_hi; b = v;
    @(posedge clk);
    #1 mt_we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra, rb, save_hi, save_lo;
    logic [63:0] p;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; mt_we = 1'b0; mt_hi = 1'b0;
    #12;
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/hi", hi, 32'd0);
    check("reset/lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 0, 0);
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 0, 0);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0, 0);
    run_op("div_by_zero", 3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10, 0, 0);
    run_op("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0, 0);
    run_op("multu_max_start_wins", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 5, 1, 0);
    run_op("div_13_m4", 3'd2, 32'd13, 32'hFFFF_FFFC, 32'd1, 32'hFFFF_FFFD, 10, 0, 0);

    // MTHI / MTLO in idle
    mt_write(1'b1, 32'h1234_5678);
    check("mthi/hi", hi, 32'h1234_5678);
    check("mthi/busy", 32'(busy), 32'd0);
    mt_write(1'b0, 32'hCAFE_F00D);
    check("mtlo/lo", lo, 32'hCAFE_F00D);
    check("mtlo/hi_kept", hi, 32'h1234_5678);

    // MTHI pulsed mid-run must be dropped
    run_op("divu_mid_mt", 3'd3, 32'd50, 32'd6, 32'd2, 32'd8, 10, 0, 1);

    // Reset during a DIV aborts immediately
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/hi", hi, 32'd0);
    check("abort/lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("mult_after_abort", 3'd0, 32'd7, 32'd6, 32'd0, 32'd42, 5, 0, 0);

`ifdef MDU_MADD_EN
    mt_write(1'b1, 32'd0);
    mt_write(1'b0, 32'hFFFF_FFFF);
    run_op("maddu_carry", 3'd5, 32'd1, 32'd1, 32'd1, 32'd0, 5, 0, 0);
    run_op("msub_2x3", 3'd6, 32'd2, 32'd3, 32'd0, 32'hFFFF_FFFA, 5, 0, 0);
`else
    save_hi = hi; save_lo = lo;
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd1; b = 32'd1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("maddu_off/busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    check("maddu_off/hi", hi, save_hi);
    check("maddu_off/lo", lo, save_lo);
`endif

    // A few random unsigned ops against a 64-bit reference
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      p  = 64'(ra) * 64'(rb);
      run_op("rand_multu", 3'd1, ra, rb, p[63:32], p[31:0], 5, 0, 0);
      rb = 32'($urandom_range(1, 65535));
      run_op("rand_divu", 3'd3, ra, rb, ra % rb, ra / rb, 10, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
